// File: rtl/decode_issue_queue.sv
// decode_issue_queue: RV32 decoder feeding a valid/ready issue FIFO with a registered head.
// Optional RV32M decode is enabled by defining DECODE_RVM_EN.
module decode_issue_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             hazard,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [XLEN-1:0]  out_pc,
  output logic [39:0]      out_ctrl,
  output logic [CNT_W-1:0] count,
  output logic             locked
);
  localparam int PW = $clog2(DEPTH);
  logic [31:0]      r_instr_q [DEPTH];
  logic [XLEN-1:0]  r_pc_q    [DEPTH];
  logic [39:0]      r_ctrl_q  [DEPTH];
  logic [PW-1:0]    r_wr, r_rd;
  logic [CNT_W-1:0] r_count;
  logic             r_locked;
  logic [31:0]      r_out_instr;
  logic [XLEN-1:0]  r_out_pc;
  logic [39:0]      r_out_ctrl;
  logic [6:0] w_op, w_f7;
  logic [4:0] w_rd, w_rs1;
  logic [2:0] w_f3;
  logic [2:0] w_alu, w_mul, w_div, w_st, w_csel;
  logic [4:0] w_ld;
  logic [3:0] w_cmp;
  logic w_br, w_mr, w_mw, w_rw, w_src, w_cmpf, w_auipc, w_lui, w_jal, w_jalr;
  logic w_cw, w_cr, w_tr, w_mi, w_di, w_ill;
  logic [39:0] w_dec;
  logic w_in_ready, w_push, w_out_valid, w_pop;
  logic [PW-1:0] w_rd_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  function automatic logic [2:0] f_alu(input logic [2:0] f3, input logic alt);
    f_alu = f3 == 3'b000 ? {2'b00, alt} : f3 == 3'b001 ? 3'b101 : f3[2:1] == 2'b01 ? 3'b001 :
            f3 == 3'b100 ? 3'b100 : f3 == 3'b101 ? {2'b11, alt} : f3 == 3'b110 ? 3'b011 : 3'b010;
  endfunction
  assign w_op  = in_instr[6:0];
  assign w_rd  = in_instr[11:7];
  assign w_f3  = in_instr[14:12];
  assign w_rs1 = in_instr[19:15];
  assign w_f7  = in_instr[31:25];
  always_comb begin
    w_alu = '0; w_mul = '0; w_div = '0; w_st = '0; w_ld = '0; w_cmp = '0; w_csel = '0;
    w_br = 1'b0; w_mr = 1'b0; w_mw = 1'b0; w_rw = 1'b0; w_src = 1'b0; w_cmpf = 1'b0;
    w_auipc = 1'b0; w_lui = 1'b0; w_jal = 1'b0; w_jalr = 1'b0;
    w_cw = 1'b0; w_cr = 1'b0; w_tr = 1'b0; w_mi = 1'b0; w_di = 1'b0; w_ill = 1'b0;
    case (w_op)
      7'b0110011: begin
        w_rw = 1'b1;
        if (w_f7 == 7'h01) begin
`ifdef DECODE_RVM_EN
          w_mi  = !w_f3[2];
          w_di  = w_f3[2];
          w_mul = w_f3[2] ? 3'd0 : {1'b0, w_f3[1:0]} + 3'd1;
          w_div = w_f3[2] ? {1'b0, w_f3[1:0]} + 3'd1 : 3'd0;
`else
          w_ill = 1'b1;
`endif
        end else begin
          w_ill  = !(w_f7 == 7'h00 || (w_f7 == 7'h20 && (w_f3 == 3'b000 || w_f3 == 3'b101)));
          w_alu  = f_alu(w_f3, w_f7[5]);
          w_cmpf = w_f3[2:1] == 2'b01;
          w_cmp  = w_cmpf ? {2'b00, w_f3[0], !w_f3[0]} : 4'd0;
        end
      end
      7'b0010011: begin
        w_rw   = 1'b1;
        w_src  = 1'b1;
        w_ill  = (w_f3 == 3'b001 && w_f7 != 7'h00) || (w_f3 == 3'b101 && w_f7 != 7'h00 && w_f7 != 7'h20);
        w_alu  = f_alu(w_f3, w_f3 == 3'b101 && w_f7[5]);
        w_cmpf = w_f3[2:1] == 2'b01;
        w_cmp  = w_cmpf ? {w_f3[0], !w_f3[0], 2'b00} : 4'd0;
      end
      7'b0000011: begin
        w_rw  = 1'b1;
        w_mr  = 1'b1;
        w_src = 1'b1;
        w_ld  = w_f3 == 3'b000 ? 5'd1 : w_f3 == 3'b001 ? 5'd2 : w_f3 == 3'b010 ? 5'd4 :
                w_f3 == 3'b100 ? 5'd8 : w_f3 == 3'b101 ? 5'd16 : 5'd0;
        w_ill = w_ld == 5'd0;
      end
      7'b0100011: begin
        w_mw  = 1'b1;
        w_src = 1'b1;
        w_st  = w_f3 == 3'b000 ? 3'd1 : w_f3 == 3'b001 ? 3'd2 : w_f3 == 3'b010 ? 3'd4 : 3'd0;
        w_ill = w_st == 3'd0;
      end
      7'b1100011: begin
        w_br  = 1'b1;
        w_alu = 3'b001;
        w_ill = w_f3[2:1] == 2'b01;
      end
      7'b0110111: begin w_lui = 1'b1; w_rw = 1'b1; w_src = 1'b1; end
      7'b0010111: begin w_auipc = 1'b1; w_rw = 1'b1; w_src = 1'b1; end
      7'b1101111: begin w_jal = 1'b1; w_rw = 1'b1; end
      7'b1100111: begin w_jalr = 1'b1; w_rw = 1'b1; w_src = 1'b1; w_ill = w_f3 != 3'b000; end
      7'b0001111: w_ill = w_f3 != 3'b000;
      7'b1110011: begin
        if (w_f3 == 3'b000) begin
          w_tr  = in_instr[31:7] == 25'h0604000;
          w_ill = !w_tr;
        end else begin
          w_ill  = w_f3 == 3'b100;
          w_csel = w_f3;
          w_rw   = 1'b1;
          w_cw   = w_f3[1:0] == 2'b01 || w_rs1 != 5'd0;
          w_cr   = w_f3[1:0] != 2'b01 || w_rd != 5'd0;
        end
      end
      default: w_ill = 1'b1;
    endcase
  end
  // An illegal word carries only the illegal flag so no side effect can leak downstream.
  assign w_dec = w_ill ? {1'b1, 39'd0} :
    {1'b0, w_di, w_mi, w_tr, w_cr, w_cw, w_csel, w_jalr, w_jal, w_lui, w_auipc, w_cmpf, w_src,
     w_rw && w_rd != 5'd0, w_mw, w_mr, w_br, w_cmp, w_ld, w_st, w_div, w_mul, w_alu};
  assign w_in_ready  = rst_n && !flush && !r_locked && r_count != CNT_W'(DEPTH);
  assign w_push      = in_valid && w_in_ready && in_instr != 32'h0;
  assign w_out_valid = r_count != '0 && !hazard && !flush;
  assign w_pop       = w_out_valid && out_ready;
  assign w_rd_nxt    = r_rd + PW'(w_pop);
  assign w_cnt_nxt   = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_wr     <= '0;
      r_rd     <= '0;
      r_count  <= '0;
      r_locked <= 1'b0;
    end else begin
      r_wr     <= r_wr + PW'(w_push);
      r_rd     <= w_rd_nxt;
      r_count  <= w_cnt_nxt;
      r_locked <= r_locked || (w_push && w_dec[39]);
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr_q[r_wr] <= in_instr;
      r_pc_q[r_wr]    <= in_pc;
      r_ctrl_q[r_wr]  <= w_dec;
    end
  end
  // The head register is preloaded with the next head; an empty queue takes the word being pushed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_instr <= '0;
      r_out_pc    <= '0;
      r_out_ctrl  <= '0;
    end else if (!flush && w_cnt_nxt != '0) begin
      r_out_instr <= r_count == CNT_W'(w_pop) ? in_instr : r_instr_q[w_rd_nxt];
      r_out_pc    <= r_count == CNT_W'(w_pop) ? in_pc    : r_pc_q[w_rd_nxt];
      r_out_ctrl  <= r_count == CNT_W'(w_pop) ? w_dec    : r_ctrl_q[w_rd_nxt];
    end
  end
  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_instr = r_out_instr;
  assign out_pc    = r_out_pc;
  assign out_ctrl  = r_out_ctrl;
  assign count     = r_count;
  assign locked    = r_locked;
endmodule

// File: tb/tb_decode_issue_queue.sv
// tb_decode_issue_queue: decode table, directed queue corners and a randomized queue model.
module tb_decode_issue_queue;
  localparam int DEPTH = 4;
  localparam int NV = 16;
  localparam logic [39:0] BR = 40'd1 << 21, MR = 40'd1 << 22, MW = 40'd1 << 23, RW = 40'd1 << 24;
  localparam logic [39:0] SRC = 40'd1 << 25, CMP = 40'd1 << 26, LUI = 40'd1 << 28, JAL = 40'd1 << 29;
  localparam logic [39:0] CW = 40'd1 << 34, CR = 40'd1 << 35, TR = 40'd1 << 36, MI = 40'd1 << 37, IL = 40'd1 << 39;
  typedef struct { logic [31:0] instr; logic [39:0] ctrl; } vec_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc; logic [39:0] ctrl; } ent_t;
  logic clk = 0, rst_n = 0, flush = 0, hazard = 0, in_valid = 0, out_ready = 0;
  logic [31:0] in_instr = 0, in_pc = 0;
  logic in_ready, out_valid, locked;
  logic [31:0] out_instr, out_pc;
  logic [39:0] out_ctrl;
  logic [2:0] count;
  int checks = 0, failures = 0;
  vec_t tv [NV];
  ent_t q [$];
  logic m_locked;
  always #5 clk = ~clk;
  decode_issue_queue #(.XLEN(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .hazard(hazard), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_ctrl(out_ctrl), .count(count), .locked(locked));
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic settle();
    #2;
  endtask
  task automatic push(input logic [31:0] ins, input logic [31:0] pc);
    in_valid = 1; in_instr = ins; in_pc = pc;
    tick();
    in_valid = 0;
  endtask
  initial begin
    tv[0]  = '{32'h00500093, RW | SRC};
    tv[1]  = '{32'h002081B3, RW};
    tv[2]  = '{32'h402081B3, RW | 40'd1};
    tv[3]  = '{32'h00000033, 40'd0};
    tv[4]  = '{32'h0020A183, (40'd1 << 14) | MR | SRC | RW};
    tv[5]  = '{32'h0020A223, (40'd1 << 11) | MW | SRC};
    tv[6]  = '{32'h00208063, BR | 40'd1};
    tv[7]  = '{32'h123452B7, LUI | RW | SRC};
    tv[8]  = '{32'h30009073, (40'd1 << 31) | CW};
    tv[9]  = '{32'h300021F3, (40'd2 << 31) | CR | RW};
    tv[10] = '{32'h30200073, TR};
    tv[11] = '{32'h0020A1B3, (40'd1 << 17) | CMP | RW | 40'd1};
`ifdef DECODE_RVM_EN
    tv[12] = '{32'h022081B3, (40'd1 << 3) | MI | RW};
`else
    tv[12] = '{32'h022081B3, IL};
`endif
    tv[13] = '{32'hFFFFFFFF, IL};
    tv[14] = '{32'h000000EF, JAL | RW};
    tv[15] = '{32'h4030D193, 40'd7 | SRC | RW};
    tick(); tick();
    settle();
    chk("rst_count", count, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_ctrl", out_ctrl, 0);
    chk("rst_out_instr", out_instr, 0);
    rst_n = 1;
    settle();
    chk("in_ready_after_rst", in_ready, 1);
    for (int i = 0; i < NV; i++) begin
      in_valid = 1; in_instr = tv[i].instr; in_pc = 32'h1000 + i * 4;
      settle();
      chk("tv_in_ready", in_ready, 1);
      tick();
      in_valid = 0;
      settle();
      chk("tv_out_valid", out_valid, 1);
      chk("tv_count", count, 1);
      chk("tv_instr", out_instr, tv[i].instr);
      chk("tv_ctrl", out_ctrl, tv[i].ctrl);
      chk("tv_locked", locked, tv[i].ctrl[39]);
      out_ready = 1;
      tick();
      out_ready = 0;
      if (tv[i].ctrl[39]) begin
        flush = 1; tick(); flush = 0;
      end
      settle();
      chk("tv_drained", count, 0);
    end
    push(32'h002081B3, 32'h10);
    push(32'h402081B3, 32'h14);
    settle();
    chk("b2b_count", count, 2);
    chk("b2b_alu0", out_ctrl[2:0], 3'b000);
    out_ready = 1;
    tick();
    settle();
    chk("b2b_alu1", out_ctrl[2:0], 3'b001);
    tick();
    out_ready = 0;
    for (int i = 0; i < 4; i++) push(32'h00000013, 32'h100 + i * 4);
    settle();
    chk("full_count", count, 4);
    in_valid = 1; in_instr = 32'h00000013; in_pc = 32'h110; out_ready = 1;
    settle();
    chk("full_in_ready", in_ready, 0);
    chk("full_out_valid", out_valid, 1);
    chk("full_head_pc", out_pc, 32'h100);
    tick();
    settle();
    chk("full_pop_count", count, 3);
    chk("full_in_ready2", in_ready, 1);
    chk("full_head2", out_pc, 32'h104);
    tick();
    in_valid = 0;
    settle();
    chk("wrap_count", count, 3);
    for (int i = 0; i < 3; i++) begin
      chk("wrap_order", out_pc, 32'h108 + i * 4);
      tick();
      settle();
    end
    out_ready = 0;
    chk("wrap_empty", count, 0);
    chk("hold_pc", out_pc, 32'h110);
    push(32'h00000013, 32'h20);
    push(32'h00000000, 32'h24);
    push(32'h00000033, 32'h28);
    settle();
    chk("zero_drop_count", count, 2);
    out_ready = 1;
    tick();
    out_ready = 0;
    settle();
    chk("x0_instr", out_instr, 32'h00000033);
    chk("x0_regwrite", out_ctrl[24], 0);
    out_ready = 1; tick(); out_ready = 0;
    push(32'hFFFFFFFF, 32'h200);
    settle();
    chk("ill_flag", out_ctrl[39], 1);
    chk("ill_locked", locked, 1);
    in_valid = 1; in_instr = 32'h00000013;
    for (int i = 0; i < 10; i++) begin
      settle();
      chk("lock_in_ready", in_ready, 0);
      chk("lock_count", count, 1);
      tick();
    end
    flush = 1; hazard = 1; out_ready = 1;
    settle();
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 0);
    tick();
    flush = 0; hazard = 0; in_valid = 0; out_ready = 0;
    settle();
    chk("flush_count", count, 0);
    chk("flush_locked", locked, 0);
    chk("flush_in_ready_after", in_ready, 1);
    push(32'h00000013, 32'h300);
    push(32'h00000013, 32'h304);
    hazard = 1; out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("hz_out_valid", out_valid, 0);
      chk("hz_count", count, 2);
      tick();
    end
    hazard = 0;
    settle();
    chk("hz_pop1", out_pc, 32'h300);
    tick();
    settle();
    chk("hz_pop2_valid", out_valid, 1);
    chk("hz_pop2", out_pc, 32'h304);
    tick();
    settle();
    chk("hz_empty", count, 0);
    chk("hz_hold", out_pc, 32'h304);
    out_ready = 0;
    m_locked = 0;
    for (int c = 0; c < 3000; c++) begin
      int k;
      logic e_ir, e_ov;
      k = $urandom_range(0, NV + 1);
      rst_n = $urandom_range(0, 199) != 0;
      flush = $urandom_range(0, 15) == 0;
      hazard = $urandom_range(0, 7) == 0;
      in_valid = $urandom_range(0, 2) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      in_instr = k < NV ? tv[k].instr : 32'h0;
      in_pc = $urandom;
      settle();
      e_ir = rst_n && !flush && !m_locked && q.size() < DEPTH;
      e_ov = q.size() != 0 && !hazard && !flush;
      chk("rnd_in_ready", in_ready, e_ir);
      chk("rnd_out_valid", out_valid, e_ov);
      chk("rnd_count", count, q.size());
      chk("rnd_locked", locked, m_locked);
      if (e_ov) begin
        chk("rnd_instr", out_instr, q[0].instr);
        chk("rnd_pc", out_pc, q[0].pc);
        chk("rnd_ctrl", out_ctrl, q[0].ctrl);
      end
      if (!rst_n || flush) begin
        q.delete();
        m_locked = 0;
      end else begin
        if (e_ov && out_ready) void'(q.pop_front());
        if (in_valid && e_ir && k < NV) begin
          q.push_back('{tv[k].instr, in_pc, tv[k].ctrl});
          m_locked = tv[k].ctrl[39];
        end
      end
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/decode_issue_queue.md
Name: decode_issue_queue

Overview:
- Decode stage successor: decodes fetched RV32 instructions into a fixed control word, then buffers them in a parametrised FIFO between fetch and execute.
- Valid/ready on both sides; registered output.
- Adds flush, illegal-instruction lock, zero-instruction drop and rd==x0 write suppression.

Parameters:
- XLEN, 32, PC and instruction-address width.
- DEPTH, 4, queue entries; power of two, ≥2.
- CNT_W, $clog2(DEPTH)+1, width of occupancy count.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset, sampled on rising clk
- flush  in  1  discard all entries and the current input
- hazard  in  1  downstream hazard; blocks pop
- in_valid  in  1  fetch offers instruction
- in_ready  out  1  queue accepts instruction
- in_instr  in  32  instruction word
- in_pc  in  XLEN  instruction PC
- out_valid  out  1  head entry presented
- out_ready  in  1  execute consumes head
- out_instr  out  32  head instruction
- out_pc  out  XLEN  head PC
- out_ctrl  out  40  head control word; fields listed LSB-first below
- count  out  CNT_W  occupancy
- locked  out  1  illegal instruction enqueued, awaiting flush

out_ctrl layout, LSB first:
- alusel[3], mulsel[3], divsel[3], storecntrl[3] (one-hot SB/SH/SW), loadcntrl[5] (one-hot LB/LH/LW/LBU/LHU), cmpcntrl[4] (one-hot SLT/SLTU/SLTI/SLTIU)
- branch, memread, memwrite, regwrite, alusrc, compare, auipc, lui, jal, jalr
- csrsel[3], csrwrite, csrread, trap_ret, mul_inst, div_inst, illegal

Behaviour:
- Reset (rst_n=0 at a clk edge): pointers, count and locked go to 0; out_valid=0; out_instr/out_pc/out_ctrl=0; in_ready=0 while rst_n=0.
- Decode encodings:
  - RV32I/Zicsr ALU codes: ADD 000, SUB 001, AND 010, OR 011, XOR 100, SLL 101, SRL 110, SRA 111. Immediate forms use the same codes with alusrc=1.
  - Loads: memread=1, alusrc=1. Stores: memwrite=1, alusrc=1.
  - CSRRW/CSRRWI: csrread=0 when rd==0. CSRRS/CSRRC (and immediate forms): csrwrite=0 when rs1==0.
  - MRET (funct12 0x302) sets trap_ret.
  - Unknown opcode, funct3 or funct7 sets illegal=1 and clears regwrite, memwrite and csrwrite.
  - regwrite forced 0 whenever rd==0 (all formats).
- in_ready = rst_n & !flush & !locked & (count<DEPTH). Push occurs on in_valid & in_ready.
- No pass-through. When full, a same-cycle pop does not enable a push; in_ready stays 0.
- in_instr==32'h0 is consumed (handshake completes) but not enqueued; count unchanged.
- Illegal instruction is enqueued with illegal=1, then locked=1 from the next cycle. in_ready stays 0 until flush.
- Latency: push at edge N → out_valid=1 in cycle N+1 at the earliest. Output fields are registered head-entry values.
- out_valid = (count!=0) & !hazard & !flush. Pop occurs on out_valid & out_ready.
- Simultaneous push and pop (not full): count unchanged; pointers both advance, wrapping modulo DEPTH.
- Flush cycle: no push, no pop. Next edge: count=0, pointers=0, locked=0. flush overrides hazard and in_valid.
- Reset mid-operation discards all entries identically to flush.
- out_* fields hold the last head value when out_valid=0; they are not cleared.

Optional Feature:
- Macro: DECODE_RVM_EN.
- Defined: R-type funct7=0x01 decodes MUL/MULH/MULHSU/MULHU (mulsel 1–4, mul_inst=1) and DIV/DIVU/REM/REMU (divsel 1–4, div_inst=1).
- Undefined: those encodings set illegal=1 with mulsel=divsel=0. Mul/div logic is absent.

Test Plan:
- Reset, then push 0x00500093 (ADDI x1,x0,5) → one cycle later out_valid=1, alusel=000, alusrc=1, regwrite=1, count=1.
- Push 0x002081B3 and 0x402081B3 back-to-back with out_ready=0, DEPTH=4 → count=2; pop in order gives alusel 000 then 001.
- Fill 4 entries, hold in_valid=1 and out_ready=1 → in_ready=0 that cycle; pop reduces count to 3; next cycle push accepted, pointers wrap.
- Push 0x00000013, then 0x00000000, then 0x00000033 (ADD x0,x0,x0) → 0x0 dropped (count 2); entry 2 has regwrite=0.
- Push 0xFFFFFFFF → head illegal=1, locked=1, in_ready=0 for 10 cycles; assert flush → count=0, locked=0, in_ready=1.
- With DECODE_RVM_EN, push 0x022081B3 → mul_inst=1, mulsel=001. Without the macro, same push → illegal=1, locked=1.
- hazard=1 with 2 entries, out_ready=1 → out_valid=0, count stays 2; release hazard → two pops on consecutive cycles.
